riscv_run_ctrl: RTL and testbench
=================================

# riscv_run_ctrl

Run controller for the single-cycle RISC-V core. It loads a program into instruction memory from a word stream and holds the core in reset for a fixed number of cycles. It then releases the core, counts execution cycles until the core raises `finish_flag` or a cycle budget expires, and parks the core back in reset. It sits between the bench or host loader and the core's `rst`, `finish_flag` and instruction-memory write port.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `DATA_W`, 32: instruction word width.
- `CNT_W`, 32: cycle counter width.
- `TIMEOUT_CYCLES`, 1000: maximum RUN cycles; must be ≥1 and < 2^CNT_W.
- `RST_HOLD`, 2: cycles the core is held in reset after load, before release; must be ≥1.

Ports:
- `clock`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load or run; sampled in IDLE/DONE/TIMEOUT.
- `reload`  in  1  with `start` in DONE/TIMEOUT: 1 = reload program, 0 = rerun existing image.
- `abort`  in  1  return to IDLE from any state.
- `ld_valid`  in  1  load word valid.
- `ld_ready`  out  1  controller accepts load word.
- `ld_data`  in  DATA_W  load word.
- `ld_last`  in  1  marks final word of program.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_addr`  out  ADDR_W  write word address.
- `imem_wdata`  out  DATA_W  write data.
- `core_rst`  out  1  active-high reset to core.
- `finish_flag`  in  1  core finished (from core).
- `cycle_count`  out  CNT_W  RUN cycles elapsed.
- `words_loaded`  out  ADDR_W+1  words written in last load.
- `busy`  out  1  state is LOAD, HOLD or RUN.
- `done`  out  1  run ended by `finish_flag`.
- `timeout`  out  1  run ended by budget expiry.

## Operation
- States: IDLE, LOAD, HOLD, RUN, DONE, TIMEOUT.
- `core_rst` is 1 in every state except RUN.
- IDLE:
  - `start` → LOAD, regardless of `reload`.
  - Clears the load pointer, `words_loaded`, `cycle_count`, `done` and `timeout`.
- LOAD:
  - `ld_ready`=1.
  - Handshake is `ld_valid & ld_ready`.
  - On each handshake: `imem_we`=1 combinationally, `imem_addr`=pointer, `imem_wdata`=`ld_data`. The pointer and `words_loaded` then increment.
  - A handshake with `ld_last`=1, or at pointer = 2^ADDR_W−1 (memory full), → HOLD.
  - On full, further words are not accepted.
- HOLD: a counter runs RST_HOLD cycles, then → RUN.
- RUN:
  - At each edge, if `finish_flag`=1 → DONE, with the count not incremented.
  - Otherwise `cycle_count` increments. If the new value equals TIMEOUT_CYCLES → TIMEOUT.
  - `finish_flag` is ignored outside RUN.
- DONE / TIMEOUT:
  - `done` or `timeout` is held at 1, and `cycle_count` is frozen.
  - `start` with `reload`=1 → LOAD, with pointer, `words_loaded`, count and flags cleared.
  - `start` with `reload`=0 → HOLD, with count and flags cleared and `words_loaded` kept.
- `abort`:
  - → IDLE on the next edge from any state and clears flags.
  - Abort beats `start` and `finish_flag`.
  - A handshake in the same cycle as `abort` is not accepted: `ld_ready` is forced to 0 while `abort`=1.

## Timing
- Reset values (async assert): state IDLE, `core_rst`=1, `ld_ready`=0, `imem_we`=0, `imem_addr`=0, `cycle_count`=0, `words_loaded`=0, `busy`=0, `done`=0, `timeout`=0.
- Reset release is synchronised internally: the first state change can occur on the second edge after `rst` rises.
- All outputs except `imem_we`, `imem_addr`, `imem_wdata` and `ld_ready` are registered (Moore).
- `start` sampled at edge k → LOAD (or HOLD) from edge k; `ld_ready`=1 in the cycle after edge k.
- Load is 1 word per cycle at full throughput, with no bubble between words.
- A final handshake at edge t → HOLD from t. `core_rst` falls at edge t+RST_HOLD.
- `finish_flag` first high in RUN cycle K (1-based) → `cycle_count`=K−1, `done`=1 after that edge.
- No finish → `timeout`=1 and `cycle_count`=TIMEOUT_CYCLES after the TIMEOUT_CYCLES-th RUN edge.
- If `finish_flag` is high on that same edge, DONE wins and the count is TIMEOUT_CYCLES−1.
- Reset mid-operation: all outputs return to reset values immediately; no partial state survives.

## Test plan
- **Reset:** assert `rst`=0 mid-RUN → `core_rst`=1, `busy`=0, `cycle_count`=0 immediately; idle after release.
- **Load and run:** 5 words with `ld_last` on word 5 → addresses 0..4 written, `words_loaded`=5. `core_rst` low RST_HOLD=2 cycles after the last handshake. `finish_flag` raised in RUN cycle 40 → `done`=1, `cycle_count`=39.
- **Backpressure and full:** `ld_valid` toggling every cycle → no lost or duplicated words. With ADDR_W=3 and 9 words without `ld_last` → 8 written, `ld_ready` drops after word 8, state HOLD.
- **Timeout:** TIMEOUT_CYCLES=10, `finish_flag` held low → `timeout`=1, `cycle_count`=10, `core_rst`=1. Same bench with `finish_flag` rising on the 10th RUN edge → `done`=1, count 9.
- **Rerun:** from DONE, `start` with `reload`=0 → no `imem_we` pulses, `words_loaded` unchanged, HOLD then RUN, count restarts at 0.
- **Abort:** `abort` with `start` in DONE, and `abort` with `ld_valid` in LOAD → IDLE next edge, handshake not accepted, flags cleared, `core_rst`=1.

Source files
------------

// File: rtl/riscv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: streams a program into
// instruction memory, sequences core reset, and times the run.
module riscv_run_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RST_HOLD       = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              reload,
    input  logic              abort,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic              finish_flag,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   words_loaded,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t            state;
    logic              armed;
    logic [ADDR_W-1:0] ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hs;
    logic              ptr_full;
    logic [CNT_W-1:0]  cnt_inc;

    // The write port is driven straight from the handshake so a word lands
    // in memory on the same edge it is accepted.
    assign ld_ready   = (state == S_LOAD) && !abort;
    assign hs         = ld_valid && ld_ready;
    assign imem_we    = hs;
    assign imem_addr  = ptr;
    assign imem_wdata = ld_data;
    assign ptr_full   = &ptr;
    assign cnt_inc    = cycle_count + CNT_W'(1);

    // Reset release is held off one edge so the FSM never sees a runt release.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            cycle_count  <= '0;
            words_loaded <= '0;
            core_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else if (armed) begin
            if (abort) begin
                state    <= S_IDLE;
                core_rst <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        ptr          <= '0;
                        words_loaded <= '0;
                        cycle_count  <= '0;
                        done         <= 1'b0;
                        timeout      <= 1'b0;
                        if (start) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (hs) begin
                            ptr          <= ptr + ADDR_W'(1);
                            words_loaded <= words_loaded + (ADDR_W+1)'(1);
                            if (ld_last || ptr_full) begin
                                state    <= S_HOLD;
                                hold_cnt <= '0;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= S_RUN;
                            core_rst <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    S_RUN: begin
                        // A finish on the budget edge still counts as done.
                        if (finish_flag) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            core_rst <= 1'b1;
                        end else begin
                            cycle_count <= cnt_inc;
                            if (cnt_inc == CNT_LIMIT) begin
                                state    <= S_TIMEOUT;
                                timeout  <= 1'b1;
                                busy     <= 1'b0;
                                core_rst <= 1'b1;
                            end
                        end
                    end
                    S_DONE, S_TIMEOUT: begin
                        if (start) begin
                            cycle_count <= '0;
                            done        <= 1'b0;
                            timeout     <= 1'b0;
                            busy        <= 1'b1;
                            hold_cnt    <= '0;
                            if (reload) begin
                                state        <= S_LOAD;
                                ptr          <= '0;
                                words_loaded <= '0;
                            end else begin
                                state <= S_HOLD;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: directed load/run/abort/reset sequences with
// queued expectations checked by independent write and end-of-run monitors.
module tb_riscv_run_ctrl;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int TO = 45;
    localparam int RH = 2;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          reload = 1'b0;
    logic          abort = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_last = 1'b0;
    logic          finish_flag = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          core_rst;
    logic [CW-1:0] cycle_count;
    logic [AW:0]   words_loaded;
    logic          busy;
    logic          done;
    logic          timeout;

    riscv_run_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .CNT_W(CW),
        .TIMEOUT_CYCLES(TO),
        .RST_HOLD(RH)
    ) dut (
        .clock(clock),
        .rst(rst),
        .start(start),
        .reload(reload),
        .abort(abort),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .finish_flag(finish_flag),
        .cycle_count(cycle_count),
        .words_loaded(words_loaded),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          d;
        logic          t;
        logic [CW-1:0] cnt;
        logic [AW:0]   words;
    } end_t;

    wr_t  wr_q[$];
    end_t end_q[$];
    wr_t  we_cur;
    end_t ee_cur;
    logic prev_end = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input int a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic exp_end(input logic d, input logic t, input int cnt,
                           input int words);
        end_t e;
        e.d     = d;
        e.t     = t;
        e.cnt   = CW'(cnt);
        e.words = (AW+1)'(words);
        end_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_end(input int budget, input string name);
        int n;
        n = 0;
        while (!(done || timeout) && n < budget) begin
            step();
            n++;
        end
        chk(name, done || timeout, 1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last,
                        input bit gap, output int waits);
        bit hs;
        hs       = 1'b0;
        waits    = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        while (!hs && waits < 20) begin
            @(negedge clock);
            hs = ld_ready;
            @(posedge clock);
            #1;
            waits++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("send_accepted", hs, 1);
        if (gap) step();
    endtask

    // Memory-write monitor
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h",
                         imem_addr, imem_wdata);
            end else begin
                we_cur = wr_q.pop_front();
                chk("wr_addr", imem_addr, we_cur.addr);
                chk("wr_data", imem_wdata, we_cur.data);
            end
        end
    end

    // End-of-run monitor
    always @(negedge clock) begin
        if ((done || timeout) && !prev_end) begin
            if (end_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_end: done %0b timeout %0b",
                         done, timeout);
            end else begin
                ee_cur = end_q.pop_front();
                chk("end_done", done, ee_cur.d);
                chk("end_timeout", timeout, ee_cur.t);
                chk("end_count", cycle_count, ee_cur.cnt);
                chk("end_words", words_loaded, ee_cur.words);
            end
        end
        prev_end = done || timeout;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int sum;
        #1 rst = 1'b0;
        #2;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);

        @(negedge clock);
        rst   = 1'b1;
        start = 1'b1;
        step();
        chk("sync_edge1_busy", busy, 0);
        step();
        chk("sync_edge2_busy", busy, 1);
        start = 1'b0;
        chk("load_ld_ready", ld_ready, 1);

        sum = 0;
        for (int i = 0; i < 5; i++) begin
            exp_wr(i, 32'hA000_0000 + DW'(i));
            send(32'hA000_0000 + DW'(i), i == 4, 1'b0, w);
            sum += w;
        end
        chk("load_cycles", sum, 5);
        chk("load_words", words_loaded, 5);
        chk("hold_t0_core_rst", core_rst, 1);
        step();
        chk("hold_t1_core_rst", core_rst, 1);
        step();
        chk("release_core_rst", core_rst, 0);
        repeat (39) step();
        finish_flag = 1'b1;
        exp_end(1, 0, 39, 5);
        step();
        finish_flag = 1'b0;
        wait_end(5, "end_run1_seen");
        chk("done_core_rst", core_rst, 1);

        reload = 1'b0;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("rerun_count_clear", cycle_count, 0);
        chk("rerun_done_clear", done, 0);
        chk("rerun_words_kept", words_loaded, 5);
        chk("rerun_busy", busy, 1);
        exp_end(0, 1, TO, 5);
        wait_end(100, "timeout_seen");
        chk("timeout_core_rst", core_rst, 1);
        chk("timeout_busy", busy, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rerun2_release", core_rst, 0);
        repeat (TO - 1) step();
        finish_flag = 1'b1;
        exp_end(1, 0, TO - 1, 5);
        step();
        finish_flag = 1'b0;
        wait_end(5, "done_at_limit_seen");

        reload = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        reload = 1'b0;
        chk("reload_words_clear", words_loaded, 0);
        chk("reload_ld_ready", ld_ready, 1);
        for (int i = 0; i < 8; i++) begin
            exp_wr(i, 32'hB000_0000 + DW'(i * 3));
            send(32'hB000_0000 + DW'(i * 3), 1'b0, 1'b1, w);
        end
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        #1;
        chk("full_ld_ready", ld_ready, 0);
        chk("full_words", words_loaded, 8);
        chk("full_busy", busy, 1);
        step();
        ld_valid = 1'b0;
        chk("full_release", core_rst, 0);
        repeat (2) step();
        finish_flag = 1'b1;
        exp_end(1, 0, 2, 8);
        step();
        finish_flag = 1'b0;
        wait_end(5, "full_run_seen");

        start  = 1'b1;
        reload = 1'b1;
        abort  = 1'b1;
        step();
        start  = 1'b0;
        reload = 1'b0;
        abort  = 1'b0;
        chk("abort_done_busy", busy, 0);
        chk("abort_done_flag", done, 0);
        chk("abort_done_core_rst", core_rst, 1);
        chk("abort_done_ld_ready", ld_ready, 0);
        step();
        chk("idle_words_clear", words_loaded, 0);
        chk("idle_count_clear", cycle_count, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_load_entry", ld_ready, 1);
        ld_valid = 1'b1;
        ld_data  = 32'hFFFF_0000;
        abort    = 1'b1;
        #1;
        chk("abort_ld_ready", ld_ready, 0);
        chk("abort_imem_we", imem_we, 0);
        step();
        ld_valid = 1'b0;
        abort    = 1'b0;
        chk("abort_load_busy", busy, 0);
        chk("abort_load_core_rst", core_rst, 1);
        step();
        chk("abort_idle_ld_ready", ld_ready, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        exp_wr(0, 32'hC0DE_0001);
        send(32'hC0DE_0001, 1'b1, 1'b0, w);
        step();
        step();
        chk("mid_run_release", core_rst, 0);
        repeat (5) step();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_core_rst", core_rst, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", cycle_count, 0);
        chk("mid_rst_ld_ready", ld_ready, 0);
        chk("mid_rst_imem_we", imem_we, 0);
        chk("mid_rst_words", words_loaded, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clock);
        rst = 1'b1;
        step();
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_core_rst", core_rst, 1);
        chk("post_rst_count", cycle_count, 0);

        step();
        chk("wr_q_drained", wr_q.size(), 0);
        chk("end_q_drained", end_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
